// File: rtl/parking_gate_arbiter.sv
// Parking lot gate controller: arbitrates the inbound and outbound lanes for a
// single shared gate, confirms passages from the A/B sensor enter/exit pulses,
// and maintains the occupancy count with full/empty status.
module parking_gate_arbiter #(
    parameter int CAPACITY    = 25,
    parameter int CNT_W       = 5,
    parameter int OPEN_CYCLES = 16,
    parameter int TMR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             enter,
    input  logic             exit,
    output logic             grant_in,
    output logic             grant_out,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             timeout_err,
    output logic             stray_err
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IN,
        GRANT_OUT,
        CLEAR
    } state_t;

    typedef enum logic {
        DIR_IN,
        DIR_OUT
    } dir_t;

    localparam logic [CNT_W-1:0] OCC_MAX  = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    dir_t             last_served;
    logic [TMR_W-1:0] timer;

    logic elig_in;
    logic elig_out;
    logic pass_in;
    logic pass_out;
    logic expire;
    logic stray;
    logic opening;

    // Status and grants decode directly from registered state.
    assign full      = (occupancy == OCC_MAX);
    assign empty     = (occupancy == '0);
    assign grant_in  = (state == GRANT_IN);
    assign grant_out = (state == GRANT_OUT);
    assign gate_open = grant_in | grant_out;

    assign elig_in  = req_in  & ~full;
    assign elig_out = req_out & ~empty;
    assign pass_in  = grant_in  & enter;
    assign pass_out = grant_out & exit;
    assign stray    = (enter & ~grant_in) | (exit & ~grant_out);
    assign opening  = (state == IDLE) &&
                      ((state_next == GRANT_IN) || (state_next == GRANT_OUT));

    // Next-state arbitration, passage confirmation and grant expiry.
    always_comb begin
        state_next = state;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (elig_in && elig_out) begin
                    state_next = (last_served == DIR_OUT) ? GRANT_IN : GRANT_OUT;
                end else if (elig_in) begin
                    state_next = GRANT_IN;
                end else if (elig_out) begin
                    state_next = GRANT_OUT;
                end
            end
            GRANT_IN: begin
                if (enter) begin
                    state_next = CLEAR;
                end else if (timer == '0) begin
                    state_next = CLEAR;
                    expire     = 1'b1;
                end
            end
            GRANT_OUT: begin
                if (exit) begin
                    state_next = CLEAR;
                end else if (timer == '0) begin
                    state_next = CLEAR;
                    expire     = 1'b1;
                end
            end
            CLEAR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant timer: loaded when a grant opens, counts down while it is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (opening) begin
            timer <= TMR_LOAD;
        end else if (gate_open && (timer != '0)) begin
            timer <= timer - TMR_W'(1);
        end
    end

    // Served direction is captured as the grant closes; it is first consulted
    // in the IDLE after CLEAR, so this matches updating it during CLEAR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_served <= DIR_OUT;
        end else if (state_next == CLEAR) begin
            if (state == GRANT_IN) begin
                last_served <= DIR_IN;
            end else if (state == GRANT_OUT) begin
                last_served <= DIR_OUT;
            end
        end
    end

    // Occupancy count, saturating at both ends as a backstop to eligibility.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy <= '0;
        end else if (pass_in && (occupancy != OCC_MAX)) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (pass_out && (occupancy != '0)) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

    // One-cycle error pulses, registered from the cycle that caused them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
            stray_err   <= 1'b0;
        end else begin
            timeout_err <= expire;
            stray_err   <= stray;
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios plus random
// traffic, every cycle compared against a lane/gate behavioural model.
module tb_parking_gate_arbiter;

    localparam int CAP  = 3;
    localparam int CW   = 3;
    localparam int OPEN = 16;
    localparam int TW   = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_in = 1'b0;
    logic          req_out = 1'b0;
    logic          enter = 1'b0;
    logic          exit = 1'b0;
    logic          grant_in;
    logic          grant_out;
    logic          gate_open;
    logic [CW-1:0] occupancy;
    logic          full;
    logic          empty;
    logic          timeout_err;
    logic          stray_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: which lane holds the gate (0 none, 1 in, 2 out), cycles of grant
    // left, whether the post-grant closed cycle is pending, last lane served.
    int m_occ;
    int m_dir;
    int m_left;
    int m_last;
    bit m_clear;
    bit m_tout;
    bit m_stray;

    always #5 clk = ~clk;

    parking_gate_arbiter #(
        .CAPACITY   (CAP),
        .CNT_W      (CW),
        .OPEN_CYCLES(OPEN),
        .TMR_W      (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_in     (req_in),
        .req_out    (req_out),
        .enter      (enter),
        .exit       (exit),
        .grant_in   (grant_in),
        .grant_out  (grant_out),
        .gate_open  (gate_open),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty),
        .timeout_err(timeout_err),
        .stray_err  (stray_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_occ   = 0;
        m_dir   = 0;
        m_left  = 0;
        m_last  = 2;
        m_clear = 1'b0;
        m_tout  = 1'b0;
        m_stray = 1'b0;
    endfunction

    function automatic void model_close();
        m_last  = m_dir;
        m_dir   = 0;
        m_clear = 1'b1;
    endfunction

    function automatic void model_step();
        bit want_in;
        bit want_out;
        if (!reset) begin
            model_reset();
            return;
        end
        m_stray = (enter && m_dir != 1) || (exit && m_dir != 2);
        m_tout  = 1'b0;
        if (m_dir != 0) begin
            if (m_dir == 1 && enter) begin
                if (m_occ < CAP) m_occ++;
                model_close();
            end else if (m_dir == 2 && exit) begin
                if (m_occ > 0) m_occ--;
                model_close();
            end else if (m_left == 1) begin
                m_tout = 1'b1;
                model_close();
            end else begin
                m_left--;
            end
        end else if (m_clear) begin
            m_clear = 1'b0;
        end else begin
            want_in  = req_in && (m_occ < CAP);
            want_out = req_out && (m_occ > 0);
            if (want_in && want_out) m_dir = (m_last == 1) ? 2 : 1;
            else if (want_in)        m_dir = 1;
            else if (want_out)       m_dir = 2;
            if (m_dir != 0) m_left = OPEN;
        end
    endfunction

    task automatic compare_all();
        check_eq("grant_in",    grant_in,    m_dir == 1);
        check_eq("grant_out",   grant_out,   m_dir == 2);
        check_eq("gate_open",   gate_open,   m_dir != 0);
        check_eq("occupancy",   occupancy,   m_occ);
        check_eq("full",        full,        m_occ == CAP);
        check_eq("empty",       empty,       m_occ == 0);
        check_eq("timeout_err", timeout_err, m_tout);
        check_eq("stray_err",   stray_err,   m_stray);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_open(input int budget);
        int k = 0;
        while (m_dir == 0 && k < budget) begin
            tick();
            k++;
        end
        check_eq("wait_open", gate_open, 1);
    endtask

    task automatic enter_car();
        req_in = 1'b1;
        wait_open(20);
        req_in = 1'b0;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    task automatic exit_car();
        req_out = 1'b1;
        wait_open(20);
        req_out = 1'b0;
        exit = 1'b1;
        tick();
        exit = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_dir;
        int prev_dir;
        int open_cnt;
        int tout_cnt;
        model_reset();

        // Reset held with random inputs, then released while quiet.
        for (int i = 0; i < 6; i++) begin
            req_in  = 1'($urandom);
            req_out = 1'($urandom);
            enter   = 1'($urandom);
            exit    = 1'($urandom);
            tick();
        end
        check_eq("rst_empty", empty, 1);
        req_in = 1'b0; req_out = 1'b0; enter = 1'b0; exit = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_idle", gate_open, 0);

        // Single entry: grant one cycle after the request, gate closes on pulse.
        req_in = 1'b1;
        tick();
        check_eq("entry_grant", grant_in, 1);
        req_in = 1'b0;
        tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check_eq("entry_occ", occupancy, 1);
        check_eq("entry_empty", empty, 0);
        check_eq("entry_closed", gate_open, 0);
        tick();

        // Tie fairness with both requests held.
        enter_car();
        req_in = 1'b1;
        req_out = 1'b1;
        prev_dir = 0;
        for (int i = 0; i < 6; i++) begin
            wait_open(10);
            exp_dir = (i == 0) ? ((m_last == 1) ? 2 : 1) : (3 - prev_dir);
            check_eq("tie_dir", grant_in ? 1 : 2, exp_dir);
            prev_dir = exp_dir;
            tick();
            if (exp_dir == 1) enter = 1'b1; else exit = 1'b1;
            tick();
            enter = 1'b0;
            exit = 1'b0;
        end
        req_in = 1'b0;
        req_out = 1'b0;
        tick();
        tick();

        // Full lot blocks inbound until a car leaves.
        for (int i = 0; i < 5 && m_occ < CAP; i++) enter_car();
        check_eq("full_set", full, 1);
        req_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check_eq("full_block", grant_in, 0);
        end
        req_out = 1'b1;
        wait_open(10);
        check_eq("full_out_grant", grant_out, 1);
        req_out = 1'b0;
        exit = 1'b1;
        tick();
        exit = 1'b0;
        check_eq("full_clear", full, 0);
        wait_open(10);
        check_eq("full_in_follow", grant_in, 1);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        req_in = 1'b0;
        tick();

        // Timeout: outbound grant with no exit pulse.
        exit_car();
        exit_car();
        check_eq("tmo_occ_pre", occupancy, 1);
        req_out = 1'b1;
        wait_open(10);
        req_out = 1'b0;
        open_cnt = 1;
        tout_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant_out) open_cnt++;
            if (timeout_err) tout_cnt++;
        end
        check_eq("tmo_len", open_cnt, OPEN);
        check_eq("tmo_pulses", tout_cnt, 1);
        check_eq("tmo_occ", occupancy, 1);

        // Stray enter in IDLE, then reset during an inbound grant.
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check_eq("stray_flag", stray_err, 1);
        check_eq("stray_occ", occupancy, 1);
        req_in = 1'b1;
        wait_open(10);
        tick();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("rst_mid_grant", grant_in, 0);
        check_eq("rst_mid_occ", occupancy, 0);
        req_in = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) req_in  = 1'($urandom);
            if ($urandom_range(0, 3) == 0) req_out = 1'($urandom);
            enter = ($urandom_range(0, 4) == 0);
            exit  = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 150) != 0);
            tick();
        end
        reset = 1'b1;
        enter = 1'b0;
        exit = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
